// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response bundle shared by the two requesters and the downstream port.
interface mem_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like port between the inst and data requesters; an in-order tag FIFO
// routes each response back to the source that issued it.
module mem_req_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic                clk,
    input  logic                reset,
    mem_req_arbiter_if.slave    inst,
    mem_req_arbiter_if.slave    data,
    mem_req_arbiter_if.master   mem,
    output logic [CNT_W-1:0]    inst_io_cnt,
    output logic [CNT_W-1:0]    data_io_cnt,
    output logic                idle,
    output logic                proto_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned ST_W  = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {StFree, StLockI, StLockD} state_e;

    state_e            state_q;
    logic [DEPTH-1:0]  tag_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic [ST_W-1:0]   starve_q;

    logic gnt_data, full, empty, accept, pop, head_data, lock_drop, stray;

    always_comb begin
        gnt_data = 1'b0;
        case (state_q)
            StLockI: gnt_data = 1'b0;
            StLockD: gnt_data = 1'b1;
            // Forced inst priority once data has won STARVE_LIM times in a row
            default: gnt_data = data.req && !(starve_q == ST_W'(STARVE_LIM) && inst.req);
        endcase
    end

    assign full  = (occ_q == OCC_W'(DEPTH));
    assign empty = (occ_q == '0);

    assign mem.req   = (gnt_data ? data.req : inst.req) && !full;
    assign mem.wr    = gnt_data ? data.wr    : inst.wr;
    assign mem.size  = gnt_data ? data.size  : inst.size;
    assign mem.wstrb = gnt_data ? data.wstrb : inst.wstrb;
    assign mem.addr  = gnt_data ? data.addr  : inst.addr;
    assign mem.wdata = gnt_data ? data.wdata : inst.wdata;

    assign accept    = mem.req && mem.addr_ok;
    assign pop       = mem.data_ok && !empty;
    assign stray     = mem.data_ok && empty;
    assign head_data = tag_q[rd_ptr_q];
    assign lock_drop = (state_q == StLockI && !inst.req) || (state_q == StLockD && !data.req);

    assign inst.addr_ok = accept && !gnt_data;
    assign data.addr_ok = accept && gnt_data;
    assign inst.data_ok = pop && !head_data;
    assign data.data_ok = pop && head_data;
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;

    assign idle = empty && !inst.req && !data.req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFree;
            tag_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            starve_q    <= '0;
            inst_io_cnt <= '0;
            data_io_cnt <= '0;
            proto_err   <= 1'b0;
        end else begin
            case (state_q)
                StFree: begin
                    if (mem.req && !mem.addr_ok) begin
                        state_q <= gnt_data ? StLockD : StLockI;
                    end
                end
                StLockI, StLockD: begin
                    if (lock_drop || accept) begin
                        state_q <= StFree;
                    end
                end
                default: state_q <= StFree;
            endcase

            if (accept) begin
                tag_q[wr_ptr_q] <= gnt_data;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end

            if (accept && !pop) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (pop && !accept) begin
                occ_q <= occ_q - OCC_W'(1);
            end

            // Same-source inc and dec in one cycle cancel
            case ({accept && !gnt_data, pop && !head_data})
                2'b10:   inst_io_cnt <= inst_io_cnt + CNT_W'(1);
                2'b01:   inst_io_cnt <= inst_io_cnt - CNT_W'(1);
                default: inst_io_cnt <= inst_io_cnt;
            endcase
            case ({accept && gnt_data, pop && head_data})
                2'b10:   data_io_cnt <= data_io_cnt + CNT_W'(1);
                2'b01:   data_io_cnt <= data_io_cnt - CNT_W'(1);
                default: data_io_cnt <= data_io_cnt;
            endcase

            if (!inst.req || (accept && !gnt_data)) begin
                starve_q <= '0;
            end else if (accept && gnt_data && starve_q != ST_W'(STARVE_LIM)) begin
                starve_q <= starve_q + ST_W'(1);
            end

            if (stray || lock_drop) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: grant priority, locking, FIFO full, starvation, stray responses.
module tb_mem_req_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_req_arbiter_if inst_bus ();
    mem_req_arbiter_if data_bus ();
    mem_req_arbiter_if mem_bus ();

    logic [3:0] inst_io_cnt, data_io_cnt;
    logic       idle, proto_err;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    mem_req_arbiter #(
        .DEPTH      (4),
        .CNT_W      (4),
        .STARVE_LIM (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inst        (inst_bus),
        .data        (data_bus),
        .mem         (mem_bus),
        .inst_io_cnt (inst_io_cnt),
        .data_io_cnt (data_io_cnt),
        .idle        (idle),
        .proto_err   (proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 2'd2; inst_bus.wstrb = 4'hF;
        inst_bus.addr = '0; inst_bus.wdata = '0;
        data_bus.req = 0; data_bus.wr = 0; data_bus.size = 2'd2; data_bus.wstrb = 4'hF;
        data_bus.addr = '0; data_bus.wdata = '0;
        mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = '0;

        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
        check("rst_inst_cnt", inst_io_cnt, 0);
        check("rst_data_cnt", data_io_cnt, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_idle", idle, 1);
        check("rst_mem_req", mem_bus.req, 0);

        // 1: single inst fetch
        inst_bus.req = 1; inst_bus.addr = 32'h1C00_0000; mem_bus.addr_ok = 1;
        #1;
        check("t1_mem_req", mem_bus.req, 1);
        check("t1_mem_addr", mem_bus.addr, 32'h1C00_0000);
        check("t1_inst_addr_ok", inst_bus.addr_ok, 1);
        check("t1_data_addr_ok", data_bus.addr_ok, 0);
        tick();
        inst_bus.req = 0; mem_bus.addr_ok = 0;
        #1;
        check("t1_inst_cnt1", inst_io_cnt, 1);
        check("t1_data_cnt0", data_io_cnt, 0);
        tick();
        mem_bus.data_ok = 1; mem_bus.rdata = 32'h0280_0C0C;
        #1;
        check("t1_inst_data_ok", inst_bus.data_ok, 1);
        check("t1_inst_rdata", inst_bus.rdata, 32'h0280_0C0C);
        check("t1_data_data_ok", data_bus.data_ok, 0);
        tick();
        mem_bus.data_ok = 0;
        #1;
        check("t1_inst_cnt0", inst_io_cnt, 0);

        // 2: simultaneous requests, data first, responses in order
        inst_bus.req = 1; inst_bus.addr = 32'h1C00_0004;
        data_bus.req = 1; data_bus.addr = 32'h8000_0010; data_bus.wr = 1;
        data_bus.wdata = 32'hDEAD_BEEF;
        mem_bus.addr_ok = 1;
        #1;
        check("t2_data_addr_ok", data_bus.addr_ok, 1);
        check("t2_inst_addr_ok0", inst_bus.addr_ok, 0);
        check("t2_mem_addr_d", mem_bus.addr, 32'h8000_0010);
        check("t2_mem_wdata", mem_bus.wdata, 32'hDEAD_BEEF);
        check("t2_mem_wr", mem_bus.wr, 1);
        tick();
        data_bus.req = 0; data_bus.wr = 0;
        #1;
        check("t2_inst_addr_ok", inst_bus.addr_ok, 1);
        check("t2_mem_addr_i", mem_bus.addr, 32'h1C00_0004);
        check("t2_data_cnt1", data_io_cnt, 1);
        tick();
        inst_bus.req = 0; mem_bus.addr_ok = 0;
        #1;
        check("t2_inst_cnt1", inst_io_cnt, 1);
        check("t2_data_cnt_peak", data_io_cnt, 1);
        mem_bus.data_ok = 1; mem_bus.rdata = 32'h1111_1111;
        #1;
        check("t2_resp1_data", data_bus.data_ok, 1);
        check("t2_resp1_inst", inst_bus.data_ok, 0);
        tick();
        mem_bus.rdata = 32'h2222_2222;
        #1;
        check("t2_resp2_inst", inst_bus.data_ok, 1);
        check("t2_resp2_data", data_bus.data_ok, 0);
        tick();
        mem_bus.data_ok = 0;
        #1;
        check("t2_inst_cnt0", inst_io_cnt, 0);
        check("t2_data_cnt0", data_io_cnt, 0);

        // 3: locked inst request holds the port while data waits
        inst_bus.req = 1; inst_bus.addr = 32'h1C00_0008; mem_bus.addr_ok = 0;
        #1;
        check("t3_mem_req", mem_bus.req, 1);
        tick();
        data_bus.req = 1; data_bus.addr = 32'h8000_0020;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t3_lock_addr", mem_bus.addr, 32'h1C00_0008);
            check("t3_lock_data_ok", data_bus.addr_ok, 0);
            tick();
        end
        mem_bus.addr_ok = 1;
        #1;
        check("t3_inst_acc", inst_bus.addr_ok, 1);
        check("t3_data_wait", data_bus.addr_ok, 0);
        tick();
        inst_bus.req = 0;
        #1;
        check("t3_data_acc", data_bus.addr_ok, 1);
        check("t3_mem_addr_d", mem_bus.addr, 32'h8000_0020);
        tick();
        data_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 1;
        #1;
        check("t3_resp1_inst", inst_bus.data_ok, 1);
        tick();
        check("t3_resp2_data", data_bus.data_ok, 1);
        tick();
        mem_bus.data_ok = 0;
        #1;
        check("t3_cnt0", inst_io_cnt + data_io_cnt, 0);

        // 4: FIFO full blocks the fifth request even with a same-cycle pop
        data_bus.req = 1; mem_bus.addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4_fill_acc", data_bus.addr_ok, 1);
            tick();
        end
        #1;
        check("t4_full_cnt", data_io_cnt, 4);
        check("t4_full_req", mem_bus.req, 0);
        mem_bus.data_ok = 1;
        #1;
        check("t4_full_req_pop", mem_bus.req, 0);
        check("t4_full_addr_ok", data_bus.addr_ok, 0);
        tick();
        mem_bus.data_ok = 0;
        #1;
        check("t4_after_pop_cnt", data_io_cnt, 3);
        check("t4_after_pop_acc", data_bus.addr_ok, 1);
        tick();
        data_bus.req = 0; mem_bus.addr_ok = 0;
        #1;
        check("t4_refill_cnt", data_io_cnt, 4);
        mem_bus.data_ok = 1;
        for (int i = 0; i < 4; i++) tick();
        mem_bus.data_ok = 0;
        #1;
        check("t4_drain_cnt", data_io_cnt, 0);
        check("t4_no_err", proto_err, 0);

        // 5: starvation forces inst after 8 data grants
        inst_bus.req = 1; inst_bus.addr = 32'h1C00_0010;
        data_bus.req = 1; mem_bus.addr_ok = 1;
        for (int i = 0; i < 8; i++) begin
            mem_bus.data_ok = (i > 0);
            #1;
            check("t5_data_gnt", data_bus.addr_ok, 1);
            check("t5_inst_wait", inst_bus.addr_ok, 0);
            tick();
        end
        #1;
        check("t5_inst_forced", inst_bus.addr_ok, 1);
        check("t5_data_held", data_bus.addr_ok, 0);
        tick();
        #1;
        check("t5_starve_clr", data_bus.addr_ok, 1);
        tick();
        inst_bus.req = 0; data_bus.req = 0; mem_bus.addr_ok = 0;
        tick();
        mem_bus.data_ok = 0;
        #1;
        check("t5_inst_cnt0", inst_io_cnt, 0);
        check("t5_data_cnt0", data_io_cnt, 0);
        check("t5_no_err", proto_err, 0);
        check("t5_idle", idle, 1);

        // 6: stray response with empty FIFO
        mem_bus.data_ok = 1; mem_bus.rdata = 32'h5555_AAAA;
        #1;
        check("t6_inst_data_ok", inst_bus.data_ok, 0);
        check("t6_data_data_ok", data_bus.data_ok, 0);
        tick();
        mem_bus.data_ok = 0;
        #1;
        check("t6_proto_err", proto_err, 1);
        check("t6_cnt0", inst_io_cnt + data_io_cnt, 0);
        tick();
        tick();
        check("t6_err_sticky", proto_err, 1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        check("t6_err_cleared", proto_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one sram-like memory port between the instruction requester (IF fetch path) and the data requester (EX/MEM load/store path).
- Arbitrates address-phase requests and holds each grant stable until the request is accepted.
- Records the source of every accepted request in an in-order tag FIFO and routes each data_ok/rdata back to that source.
- Exports per-source outstanding counts; inst_io_cnt feeds the IF cancel logic.

Parameters:
DEPTH, 4, tag FIFO entries = maximum outstanding requests on the shared port
CNT_W, 4, width of the outstanding counters; must hold DEPTH
STARVE_LIM, 8, consecutive data grants while inst waits before inst gets forced priority

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req / inst_wr  in  1 / 1  inst sram-like request, write flag
inst_size / inst_wstrb  in  2 / 4  access size, byte strobes
inst_addr / inst_wdata  in  32 / 32  address, write data
inst_addr_ok / inst_data_ok  out  1 / 1  inst request accepted, inst response
inst_rdata  out  32  inst response data
data_req / data_wr / data_size / data_wstrb / data_addr / data_wdata  in  1/1/2/4/32/32  data requester, same meanings as inst_*
data_addr_ok / data_data_ok / data_rdata  out  1/1/32  data responses
mem_req / mem_wr / mem_size / mem_wstrb / mem_addr / mem_wdata  out  1/1/2/4/32/32  shared downstream request
mem_addr_ok / mem_data_ok / mem_rdata  in  1/1/32  downstream handshake and data
inst_io_cnt / data_io_cnt  out  CNT_W / CNT_W  accepted-but-unanswered requests per source
idle  out  1  tag FIFO empty and no request pending
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset: FIFO empty, counters 0, FSM = FREE, starve counter 0, proto_err 0; all registered outputs 0; idle = 1.
- Grant FSM, states FREE, LOCK_I, LOCK_D:
  - FREE: grant data if data_req, else inst if inst_req. Exception: if starve counter = STARVE_LIM and inst_req, grant inst.
  - FREE -> LOCK_I / LOCK_D when mem_req && !mem_addr_ok, locking to the granted source.
  - LOCK_x: grant fixed to x; mem_* driven from x.
  - LOCK_x -> FREE on mem_addr_ok.
  - LOCK_x -> FREE if x_req drops before acceptance; set proto_err.
- mem_req = granted x_req && !full. mem_* fields are a combinational mux of the granted source.
- x_addr_ok = mem_req && mem_addr_ok && grant == x. Only the granted source ever sees addr_ok.
- Accept (mem_req && mem_addr_ok): push source tag (0 = inst, 1 = data); increment that source's io_cnt.
- Full FIFO: mem_req = 0 even if mem_data_ok pops in the same cycle. A push is never made into a full FIFO.
- Response: on mem_data_ok with FIFO non-empty:
  - pop the head;
  - assert head-source x_data_ok the same cycle (combinational);
  - x_rdata = mem_rdata, passed through for both sources;
  - decrement that io_cnt.
- mem_data_ok with FIFO empty: ignored; no counter change; proto_err = 1.
- Push and pop in the same cycle: FIFO occupancy unchanged. Per-source counters update independently, so inc and dec on the same source cancel.
- Pointers wrap modulo DEPTH.
- Starve counter:
  - increments on each data accept while inst_req = 1;
  - clears on any inst accept, or when inst_req = 0;
  - saturates at STARVE_LIM.
- Responses always return in acceptance order; the arbiter never reorders.
- idle = FIFO empty && !inst_req && !data_req.
- proto_err clears only on reset.
- Reset mid-transaction: all state drops within one cycle. Outstanding downstream responses are the system's responsibility; after reset, the FIFO is empty and any stray mem_data_ok sets proto_err.

Test Plan:
1. inst_req only, addr 0x1C000000, mem_addr_ok = 1 at cycle 0, mem_data_ok at cycle 2 with rdata 0x02800C0C -> inst_addr_ok at cycle 0; inst_io_cnt 0->1->0; inst_data_ok and inst_rdata = 0x02800C0C at cycle 2; data_* silent.
2. inst_req and data_req in the same cycle, mem_addr_ok = 1 -> data granted first; inst granted next cycle; responses returned in order data, inst; data_io_cnt and inst_io_cnt each peak at 1.
3. mem_addr_ok held 0 for 3 cycles on a locked inst request while data_req rises -> FSM stays LOCK_I; mem_addr stays on inst; data granted only after inst accepted.
4. Accept 4 requests with no responses (DEPTH = 4) -> mem_req = 0 on the 5th. One mem_data_ok -> next request accepted the following cycle.
5. data_req held 1 for 8 accepts while inst_req = 1 -> 9th grant goes to inst; starve counter returns to 0.
6. mem_data_ok with empty FIFO -> no data_ok to either source, counters stay 0, proto_err = 1 until reset.
